// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: RAM read port, decoder handshake and control/status lines.
// The master side is the fetch unit; the slave side is the RAM/decoder/controller environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              Start;
    logic              Stop;
    logic              Jump;
    logic [ADDR_W-1:0] JumpAddr;
    logic              RamEnable;
    logic              RamRW;
    logic [ADDR_W-1:0] RamAddress;
    logic [DATA_W-1:0] RamOut;
    logic [DATA_W-1:0] Instr;
    logic              InstrValid;
    logic              InstrReady;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic [15:0]       FetchCount;

    modport master (
        input  Start, Stop, Jump, JumpAddr, RamOut, InstrReady,
        output RamEnable, RamRW, RamAddress, Instr, InstrValid, PC, Busy, FetchCount
    );

    modport slave (
        output Start, Stop, Jump, JumpAddr, RamOut, InstrReady,
        input  RamEnable, RamRW, RamAddress, Instr, InstrValid, PC, Busy, FetchCount
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: issues a RAM read at PC, waits READ_LAT cycles,
// then presents the word on a valid/ready handshake; supports jump redirects and stop.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                READ_LAT = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           Clk,
    input logic           Reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_VALID} state_t;

    // Last wait-counter value before capture; unused when READ_LAT is 0.
    localparam int         LAST_I = (READ_LAT == 0) ? 0 : READ_LAT - 1;
    localparam logic [2:0] C_LAST = 3'(LAST_I);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [2:0]        r_cnt;
    logic [15:0]       r_fcount;
    logic              w_accept;
    logic              w_capture;
    logic              w_ram_en;
    logic              w_valid;
    logic              w_busy;

    assign w_accept  = (r_state == S_VALID) && bus.InstrReady;
    // A jump in the same cycle discards the word arriving from RAM.
    assign w_capture = !bus.Jump &&
                       (((r_state == S_ISSUE) && (READ_LAT == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == C_LAST)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.Start && !bus.Stop && !bus.Jump) w_next = S_ISSUE;
            S_ISSUE: w_next = (READ_LAT == 0) ? S_VALID : S_WAIT;
            S_WAIT:  if (r_cnt == C_LAST) w_next = S_VALID;
            S_VALID: if (bus.InstrReady) w_next = bus.Stop ? S_IDLE : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && bus.Jump) begin
            w_next = bus.Stop ? S_IDLE : S_ISSUE;
        end
    end

    always_comb begin
        w_ram_en = 1'b0;
        w_valid  = 1'b0;
        w_busy   = 1'b1;
        unique case (r_state)
            S_IDLE:          w_busy   = 1'b0;
            S_ISSUE, S_WAIT: w_ram_en = 1'b1;
            S_VALID:         w_valid  = 1'b1;
            default:         w_busy   = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_cnt    <= '0;
            r_fcount <= '0;
        end else begin
            if (w_accept) begin
                r_fcount <= r_fcount + 16'd1;
            end
            // An accepted word still counts when a jump lands in the same cycle.
            if (bus.Jump) begin
                r_pc <= bus.JumpAddr;
            end else if (w_accept) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (w_capture) begin
                r_instr <= bus.RamOut;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.RamEnable  = w_ram_en;
    assign bus.RamRW      = 1'b1;
    assign bus.RamAddress = w_ram_en ? r_pc : '0;
    assign bus.Instr      = r_instr;
    assign bus.InstrValid = w_valid;
    assign bus.PC         = r_pc;
    assign bus.Busy       = w_busy;
    assign bus.FetchCount = r_fcount;
endmodule
